// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit.
//   data_size_e : access size/sign encoding carried on req_size
//   lsu_state_e : sequencer states of the lsu top
//   size_bytes  : byte count of a size for a given datapath width (0 = illegal)
package lsu_pkg;

  // WORD is sign-extended on a 64-bit datapath; WORD_U zero-extends.
  typedef enum logic [2:0] {
    UNDEF  = 3'd0,
    BYTE_S = 3'd1,
    BYTE_U = 3'd2,
    HALF_S = 3'd3,
    HALF_U = 3'd4,
    WORD   = 3'd5,
    WORD_U = 3'd6,
    DWORD  = 3'd7
  } data_size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } lsu_state_e;

  // Number of bytes moved by an access; 0 flags an illegal size.
  function automatic logic [3:0] size_bytes(input data_size_e s, input int unsigned xlen);
    case (s)
      BYTE_S, BYTE_U: size_bytes = 4'd1;
      HALF_S, HALF_U: size_bytes = 4'd2;
      WORD, WORD_U:   size_bytes = 4'd4;
      DWORD:          size_bytes = (xlen == 64) ? 4'd8 : 4'd0;
      default:        size_bytes = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment and load extension (purely combinational).
//   i_size            : access size/sign
//   i_off             : byte offset of the address within a word
//   i_wdata           : right-aligned store data
//   i_rdata0/i_rdata1 : read captures of the first/second word
//   o_be0/o_be1       : byte enables of the first/second access
//   o_wdata0/o_wdata1 : lane-shifted store data, masked to each access
//   o_rdata           : merged, right-aligned and extended load result
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  data_size_e                  i_size,
  input  logic [$clog2(XLEN/8)-1:0]   i_off,
  input  logic [XLEN-1:0]             i_wdata,
  input  logic [XLEN-1:0]             i_rdata0,
  input  logic [XLEN-1:0]             i_rdata1,
  output logic [XLEN/8-1:0]           o_be0,
  output logic [XLEN/8-1:0]           o_be1,
  output logic [XLEN-1:0]             o_wdata0,
  output logic [XLEN-1:0]             o_wdata1,
  output logic [XLEN-1:0]             o_rdata
);

  localparam int NB = XLEN / 8;

  logic [3:0]      w_nbytes;
  logic [2*NB-1:0] w_mask;
  logic [2*NB-1:0] w_be_full;
  logic [31:0]     w_sh;
  logic [XLEN-1:0] w_rot;
  logic [XLEN-1:0] w_lane0;
  logic [XLEN-1:0] w_lane1;
  logic [XLEN-1:0] w_merged;

  assign w_nbytes = size_bytes(i_size, XLEN);
  assign w_mask   = (2*NB)'((32'd1 << w_nbytes) - 32'd1);

  // Enables spill from the first word into the second one when the access
  // crosses a word boundary; the upper half becomes the second access.
  assign w_be_full = w_mask << i_off;
  assign o_be0     = w_be_full[NB-1:0];
  assign o_be1     = w_be_full[2*NB-1:NB];

  // A rotate places every byte in its final lane for both accesses at once:
  // low bytes land in the upper lanes of word 0, the rest wrap to the low
  // lanes used by word 1. A shift by XLEN (off = 0) yields zero.
  assign w_sh  = 32'(i_off) << 3;
  assign w_rot = (i_wdata << w_sh) | (i_wdata >> (32'(XLEN) - w_sh));

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign w_lane0[8*gi +: 8] = {8{o_be0[gi]}};
    assign w_lane1[8*gi +: 8] = {8{o_be1[gi]}};
  end

  assign o_wdata0 = w_rot & w_lane0;
  assign o_wdata1 = w_rot & w_lane1;

  // Second capture sits above the first, so one right shift right-aligns a
  // split load; bytes beyond the size are removed by the extension below.
  assign w_merged = XLEN'({i_rdata1, i_rdata0} >> w_sh);

  always_comb begin
    o_rdata = w_merged;
    case (i_size)
      BYTE_S:  o_rdata = XLEN'($signed(w_merged[7:0]));
      BYTE_U:  o_rdata = XLEN'(w_merged[7:0]);
      HALF_S:  o_rdata = XLEN'($signed(w_merged[15:0]));
      HALF_U:  o_rdata = XLEN'(w_merged[15:0]);
      WORD:    o_rdata = XLEN'($signed(w_merged[31:0]));
      WORD_U:  o_rdata = XLEN'(w_merged[31:0]);
      default: o_rdata = w_merged;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, issues one or two
// word-aligned memory accesses and returns a single-cycle response.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_*                   : request handshake, size, address, store data
//   rsp_valid/rdata/err     : one-cycle completion with extended load data
//   mem_req/we/addr/be/wdata: memory request, held until mem_gnt
//   mem_gnt/rvalid/rdata    : memory grant and read return
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  data_size_e        req_size,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_e      r_state, w_state_next;
  logic            r_write;
  data_size_e      r_size;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_err;
  logic [XLEN-1:0] r_rdata0;
  logic [XLEN-1:0] r_rdata1;

  logic            w_accept;
  logic [3:0]      w_req_bytes;
  logic            w_req_cross;
  logic            w_req_err;
  logic            w_split;
  logic [XLEN-1:0] w_base;
  logic [NB-1:0]   w_be0, w_be1;
  logic [XLEN-1:0] w_wdata0, w_wdata1;
  logic [XLEN-1:0] w_rdata_ext;

  // Gated by rst_n so the port reads 0 while reset is held.
  assign req_ready = (r_state == IDLE) && rst_n;
  assign w_accept  = req_valid && req_ready;

  // Legality is decided on the incoming request so an error costs no access.
  assign w_req_bytes = size_bytes(req_size, XLEN);
  assign w_req_cross = (32'(req_addr[OFFW-1:0]) + 32'(w_req_bytes)) > 32'(NB);
  assign w_req_err   = (w_req_bytes == 4'd0) || (w_req_cross && !SPLIT_MISALIGNED);

  assign w_base  = {r_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign w_split = |w_be1;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_size   (r_size),
    .i_off    (r_addr[OFFW-1:0]),
    .i_wdata  (r_wdata),
    .i_rdata0 (r_rdata0),
    .i_rdata1 (r_rdata1),
    .o_be0    (w_be0),
    .o_be1    (w_be1),
    .o_wdata0 (w_wdata0),
    .o_wdata1 (w_wdata1),
    .o_rdata  (w_rdata_ext)
  );

  // State register and captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_write  <= 1'b0;
      r_size   <= UNDEF;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_write <= req_write;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
      end
      if (r_state == WAIT0 && mem_rvalid) r_rdata0 <= mem_rdata;
      if (r_state == WAIT1 && mem_rvalid) r_rdata1 <= mem_rdata;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_next = w_req_err ? DONE : REQ0;
      REQ0:  if (mem_gnt) w_state_next = !r_write ? WAIT0 : (w_split ? REQ1 : DONE);
      WAIT0: if (mem_rvalid) w_state_next = w_split ? REQ1 : DONE;
      REQ1:  if (mem_gnt) w_state_next = r_write ? DONE : WAIT1;
      WAIT1: if (mem_rvalid) w_state_next = DONE;
      DONE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    case (r_state)
      REQ0: begin
        mem_req   = 1'b1;
        mem_we    = r_write;
        mem_addr  = w_base;
        mem_be    = w_be0;
        mem_wdata = w_wdata0;
      end
      REQ1: begin
        mem_req   = 1'b1;
        mem_we    = r_write;
        mem_addr  = w_base + XLEN'(NB);
        mem_be    = w_be1;
        mem_wdata = w_wdata1;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_err || r_write) ? '0 : w_rdata_ext;
      end
      default: ;
    endcase
  end

endmodule
